// File: rtl/stream_data_loader_pkg.sv
// Shared types and width helpers for the stream data loader.
package stream_data_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_DIV       = 3'd2,
    ST_SEND_AVG  = 3'd3,
    ST_SEND_DATA = 3'd4
  } state_t;

  localparam int DEF_DATA_W = 20;
  localparam int DEF_DEPTH  = 150;
  localparam int DEF_NCH    = 2;

  // Index width; a single-bit index is still needed for the smallest frame.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // DEPTH samples of DATA_W bits each sum to less than 2**(DATA_W+clog2(DEPTH)).
  function automatic int acc_width(input int data_w, input int depth);
    return data_w + $clog2(depth);
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_DEPTH);
  localparam int DEF_ACC_W = acc_width(DEF_DATA_W, DEF_DEPTH);

endpackage

// File: rtl/stream_data_loader_sample_buffer.sv
// Frame sample store: synchronous write, asynchronous read, contents not reset.
module sample_buffer
  import stream_data_loader_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WIDTH  = DEF_NCH * DEF_DATA_W,
  parameter int ADDR_W = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write one beat per accepted input handshake.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_data_loader.sv
// Loads a frame of multi-channel samples, emits the per-channel average,
// then replays the stored frame.
//
// state        | meaning
// -------------+-------------------------------------------------
// ST_IDLE      | waiting for start; done pulses here after a frame
// ST_LOAD      | accepting input beats, storing and accumulating
// ST_DIV       | one cycle: register acc / DEPTH into avg
// ST_SEND_AVG  | presenting the average beat
// ST_SEND_DATA | replaying stored beats 0..DEPTH-1
module stream_data_loader
  import stream_data_loader_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 150,
  parameter int NCH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic                out_is_avg,
  output logic                busy,
  output logic                done
);

  localparam int IDX_W  = idx_width(DEPTH);
  localparam int ACC_W  = acc_width(DATA_W, DEPTH);
  localparam int BEAT_W = NCH * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           wr_idx_q, rd_idx_q;
  logic [ACC_W-1:0]           acc_q [NCH];
  logic [NCH-1:0][DATA_W-1:0] avg_q;
  logic                       done_q;
  logic [BEAT_W-1:0]          buf_rd_data;
  logic                       in_fire, out_fire, frame_start;

  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign frame_start = (state_q == ST_IDLE) && start;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

  sample_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (BEAT_W),
    .ADDR_W(IDX_W)
  ) u_buf (
    .clk    (clk),
    .we     (in_fire),
    .wr_addr(wr_idx_q),
    .wr_data(in_data),
    .rd_addr(rd_idx_q),
    .rd_data(buf_rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake/output decode; outputs depend only on state so
  // they hold steady while the consumer stalls.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_is_avg = 1'b0;
    out_data   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && wr_idx_q == LAST_IDX) state_d = ST_DIV;
      end
      ST_DIV: begin
        state_d = ST_SEND_AVG;
      end
      ST_SEND_AVG: begin
        out_valid  = 1'b1;
        out_is_avg = 1'b1;
        out_data   = avg_q;
        if (out_ready) state_d = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        out_valid = 1'b1;
        out_data  = buf_rd_data;
        if (out_ready && rd_idx_q == LAST_IDX) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Indices, accumulators, averages and the completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      avg_q    <= '0;
      done_q   <= 1'b0;
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
    end else begin
      done_q <= (state_q == ST_SEND_DATA) && out_fire && (rd_idx_q == LAST_IDX);
      if (frame_start) begin
        wr_idx_q <= '0;
        rd_idx_q <= '0;
        for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
      end
      if (in_fire) begin
        wr_idx_q <= (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IDX_W'(1);
        for (int c = 0; c < NCH; c++)
          acc_q[c] <= acc_q[c] + ACC_W'(in_data[c*DATA_W +: DATA_W]);
      end
      if (state_q == ST_DIV) begin
        for (int c = 0; c < NCH; c++)
          avg_q[c] <= DATA_W'(acc_q[c] / ACC_W'(DEPTH));
      end
      if (state_q == ST_SEND_DATA && out_fire)
        rd_idx_q <= (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_data_loader.sv
// Directed bench for stream_data_loader: small DEPTH=4 instance for the
// handshake/ordering scenarios and a DEPTH=150 instance for full-scale sums.
module tb_stream_data_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        start, in_valid, in_ready, out_valid, out_ready, out_is_avg, busy, done;
  logic [15:0] in_data, out_data;
  logic        b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_is_avg, b_busy, b_done;
  logic [15:0] b_in_data, b_out_data;

  stream_data_loader #(.DATA_W(8), .DEPTH(4), .NCH(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_avg(out_is_avg), .busy(busy), .done(done)
  );

  stream_data_loader #(.DATA_W(8), .DEPTH(150), .NCH(2)) dut_big (
    .clk(clk), .reset(reset), .start(b_start),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_is_avg(b_out_is_avg), .busy(b_busy), .done(b_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int fx[4];
  int fy[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [15:0] pk(input int x, input int y);
    return {y[7:0], x[7:0]};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present fx/fy as four beats; optional idle gaps carry garbage data.
  task automatic load_beats(input bit gaps);
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = 16'hA5A5;
          tick();
        end
      end
      chk($sformatf("in_ready_b%0d", k), in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = pk(fx[k], fy[k]);
      tick();
    end
    in_valid = 1'b0;
    in_data  = 16'hFFFF;
  endtask

  // At the DIV cycle: no output yet; next cycle the average must be valid.
  task automatic check_latency();
    chk("div_out_valid", out_valid, 1'b0);
    chk("div_in_ready", in_ready, 1'b0);
    chk("div_busy", busy, 1'b1);
    tick();
    chk("lat_avg_valid", out_valid, 1'b1);
  endtask

  task automatic recv(input string tag, input logic [15:0] exp, input logic avg, input int stall);
    int w = 0;
    out_ready = (stall == 0);
    while (!out_valid && w < 10) begin
      tick();
      w++;
    end
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_is_avg"}, out_is_avg, avg);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk($sformatf("%s_hold_valid%0d", tag, i), out_valid, 1'b1);
      chk($sformatf("%s_hold_data%0d", tag, i), out_data, exp);
      chk($sformatf("%s_hold_avg%0d", tag, i), out_is_avg, avg);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic data_beats(input string tag, input int stall_k);
    for (int k = 0; k < 4; k++)
      recv($sformatf("%s_d%0d", tag, k), pk(fx[k], fy[k]), 1'b0, (k == stall_k) ? 5 : 0);
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_done_busy"}, busy, 1'b0);
    tick();
    chk({tag, "_done_clear"}, done, 1'b0);
  endtask

  initial begin
    int nb;
    int w;
    start = 0; in_valid = 0; in_data = '0; out_ready = 1;
    b_start = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 1;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_is_avg", out_is_avg, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_big_busy", b_busy, 1'b0);
    reset = 1'b1;
    tick();

    // Basic frame.
    fx = '{10, 20, 30, 41}; fy = '{1, 2, 3, 4};
    start_frame();
    chk("s1_busy", busy, 1'b1);
    load_beats(1'b0);
    check_latency();
    recv("s1_avg", pk(25, 2), 1'b1, 0);
    data_beats("s1", -1);
    check_done("s1");

    // in_valid in IDLE and during output is ignored; gappy input.
    in_valid = 1'b1; in_data = pk(99, 99);
    tick(); tick();
    chk("s2_idle_busy", busy, 1'b0);
    chk("s2_idle_in_ready", in_ready, 1'b0);
    start_frame();
    load_beats(1'b1);
    in_valid = 1'b1; in_data = pk(200, 200);
    check_latency();
    recv("s2_avg", pk(25, 2), 1'b1, 0);
    data_beats("s2", -1);
    in_valid = 1'b0;
    check_done("s2");

    // Back-pressure on average and data beat 2.
    fx = '{100, 200, 255, 0}; fy = '{7, 7, 7, 8};
    start_frame();
    load_beats(1'b0);
    check_latency();
    recv("s3_avg", pk(138, 7), 1'b1, 5);
    data_beats("s3", 2);
    check_done("s3");

    // Reset in the middle of SEND_DATA.
    fx = '{10, 20, 30, 41}; fy = '{1, 2, 3, 4};
    start_frame();
    load_beats(1'b0);
    check_latency();
    recv("s4_avg", pk(25, 2), 1'b1, 0);
    recv("s4_d0", pk(10, 1), 1'b0, 0);
    recv("s4_d1", pk(20, 2), 1'b0, 0);
    chk("s4_pre_rst_valid", out_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("s4_rst_out_valid", out_valid, 1'b0);
    chk("s4_rst_out_is_avg", out_is_avg, 1'b0);
    chk("s4_rst_busy", busy, 1'b0);
    chk("s4_rst_in_ready", in_ready, 1'b0);
    chk("s4_rst_done", done, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    fx = '{4, 4, 4, 4}; fy = '{8, 8, 8, 9};
    start_frame();
    load_beats(1'b0);
    check_latency();
    recv("s4b_avg", pk(4, 8), 1'b1, 0);
    data_beats("s4b", -1);
    check_done("s4b");

    // start held high: next frame begins in the done cycle.
    fx = '{1, 2, 3, 6}; fy = '{0, 0, 0, 3};
    start = 1'b1;
    tick();
    load_beats(1'b0);
    check_latency();
    recv("s5_avg", pk(3, 0), 1'b1, 0);
    data_beats("s5", -1);
    chk("s5_done", done, 1'b1);
    chk("s5_done_busy", busy, 1'b0);
    tick();
    chk("s5_restart_busy", busy, 1'b1);
    chk("s5_restart_in_ready", in_ready, 1'b1);
    chk("s5_restart_done", done, 1'b0);
    start = 1'b0;
    fx = '{5, 5, 5, 5}; fy = '{2, 2, 2, 2};
    load_beats(1'b0);
    check_latency();
    recv("s5b_avg", pk(5, 2), 1'b1, 0);
    data_beats("s5b", -1);
    check_done("s5b");

    // Full-scale frame on the DEPTH=150 instance.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 0; k < 150; k++) begin
      b_in_valid = 1'b1;
      b_in_data  = 16'hFFFF;
      tick();
    end
    b_in_valid = 1'b0;
    chk("big_acc0", dut_big.acc_q[0], 38250);
    chk("big_acc1", dut_big.acc_q[1], 38250);
    tick();
    chk("big_avg_valid", b_out_valid, 1'b1);
    chk("big_avg_is_avg", b_out_is_avg, 1'b1);
    chk("big_avg_data", b_out_data, 16'hFFFF);
    nb = 0;
    w  = 0;
    while (!b_done && w < 400) begin
      if (b_out_valid) nb++;
      tick();
      w++;
    end
    chk("big_beats", nb, 151);
    chk("big_done", b_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_data_loader.md
STREAM_DATA_LOADER -- requirements
Module: stream_data_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 20, meaning the bit width of one channel sample.
REQ-002 SHALL have parameter DEPTH, default 150, meaning samples per frame; legal range is 2..1024.
REQ-003 SHALL have parameter NCH, default 2, meaning channel count; sample k of all channels is carried in one beat.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port start, input, 1 bit: begins a frame; sampled only in IDLE.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, NCH*DATA_W): the input beat, with channel c at bits [c*DATA_W +: DATA_W].
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, NCH*DATA_W): the output beat, with the same packing as in_data.
REQ-009 SHALL have port out_is_avg, output, 1 bit: high when the current output beat is the per-channel average.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 SHALL have port done, output, 1 bit: a one-cycle pulse marking frame completion (enables the downstream calculator).

Function
REQ-012 SHALL implement states IDLE, LOAD, DIV, SEND_AVG and SEND_DATA.
REQ-013 SHALL transition as follows:
- IDLE->LOAD when start=1.
- LOAD->DIV on the handshake of beat DEPTH-1.
- DIV->SEND_AVG after exactly 1 cycle.
- SEND_AVG->SEND_DATA on the output handshake.
- SEND_DATA->IDLE on the handshake of beat DEPTH-1.
REQ-014 SHALL assert in_ready only in LOAD; a beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-015 SHALL store accepted beat k (k=0..DEPTH-1) at buffer index k, with the write index incremented once per accepted beat.
REQ-016 SHALL accumulate each channel during LOAD into an unsigned accumulator of DATA_W+$clog2(DEPTH) bits that never overflows; accumulators clear on the IDLE->LOAD transition.
REQ-017 SHALL, in DIV, register avg[c] = acc[c] / DEPTH (unsigned, truncating) into a DATA_W-bit register.
REQ-018 SHALL, in SEND_AVG, drive out_valid=1, out_is_avg=1 and out_data = the avg registers.
REQ-019 SHALL, in SEND_DATA, drive out_valid=1, out_is_avg=0 and out_data = buffer[rd_idx]; rd_idx starts at 0 and increments per output handshake.
REQ-020 SHALL hold out_data and out_is_avg stable while out_valid=1 and out_ready=0; out_valid SHALL NOT drop without a handshake.
REQ-021 SHALL pulse done for exactly one cycle, in the first IDLE cycle after the final SEND_DATA handshake.
REQ-022 SHALL ignore start outside IDLE, and SHALL accept start asserted in the same cycle done=1.
REQ-023 SHALL keep latency from final input handshake to out_valid=1 (average beat) at exactly 2 cycles.
REQ-024 SHALL ignore in_valid outside LOAD, with no write and no accumulation.
REQ-025 SHALL permit back-to-back throughput of 1 beat per cycle on both input and output.

Reset
REQ-026 SHALL, while reset=0, force state=IDLE, indices=0, accumulators=0, avg=0, in_ready=0, out_valid=0, out_is_avg=0, busy=0 and done=0, asynchronously.
REQ-027 SHALL NOT reset buffer contents; a frame aborted by mid-operation reset is discarded, and the next frame fully overwrites the buffer before it is read.

Structure
REQ-028 SHALL place the state encoding and the index/accumulator width localparams in package stream_data_loader_pkg.
REQ-029 SHALL implement the buffer as sub-module sample_buffer (DEPTH x NCH*DATA_W, synchronous write, asynchronous read, no reset).

Verification (DATA_W=8, DEPTH=4, NCH=2 unless stated)
REQ-030 SHALL cover this scenario: load x={10,20,30,41}, y={1,2,3,4}, out_ready=1 -> average beat x=25, y=2 with out_is_avg=1, then data beats x=10,20,30,41 in order, then done pulses once.
REQ-031 SHALL cover this scenario: in_valid toggled randomly during LOAD -> only handshaken beats are stored, and average/data are identical to REQ-030.
REQ-032 SHALL cover this scenario: out_ready=0 for 5 cycles on the average beat and on data beat 2 -> out_data held constant, with no beat lost or duplicated.
REQ-033 SHALL cover this scenario: all samples 255, DEPTH=150 -> the accumulator reaches 38250 without overflow and the average equals 255.
REQ-034 SHALL cover this scenario: reset driven low mid-SEND_DATA after beat 1 -> outputs go to reset values immediately, then a new frame x={4,4,4,4} yields average 4.
REQ-035 SHALL cover this scenario: start held high continuously -> the second frame begins the cycle done=1, and busy drops for exactly that one cycle.
